// File: rtl/reg_write_arbiter_if.sv
// Bus bundle for reg_write_arbiter: host and sequencer write requests in, merged register write port out.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface reg_write_arbiter_if;
  logic [9:0]  master_count_in;
  logic [4:0]  host_addr_in;
  logic [15:0] host_data_in;
  logic        host_valid_in;
  logic [4:0]  seq_addr_in;
  logic [15:0] seq_data_in;
  logic        seq_req_in;
  logic        seq_ack_out;
  logic [4:0]  addr_out;
  logic [15:0] data_out;
  logic        data_valid_out;
  logic        overflow_out;
  logic        overflow_clr_in;

  modport master (
    output master_count_in, host_addr_in, host_data_in, host_valid_in,
           seq_addr_in, seq_data_in, seq_req_in, overflow_clr_in,
    input  seq_ack_out, addr_out, data_out, data_valid_out, overflow_out
  );

  modport slave (
    input  master_count_in, host_addr_in, host_data_in, host_valid_in,
           seq_addr_in, seq_data_in, seq_req_in, overflow_clr_in,
    output seq_ack_out, addr_out, data_out, data_valid_out, overflow_out
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Merges queued host register writes with sequencer writes onto one registered write port.
// Grants are withheld while the master counter sits inside the blackout window.
module reg_write_arbiter #(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         FAIR_LIMIT  = 4,
  parameter logic [9:0] BLOCK_START = 10'd1016,
  parameter logic [9:0] BLOCK_END   = 10'd1023
) (
  input logic                clk_in,
  input logic                reset_in,
  reg_write_arbiter_if.slave bus
);
  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              SW         = $clog2(FAIR_LIMIT + 1);
  localparam logic [9:0]      SPAN       = BLOCK_END - BLOCK_START;
  localparam logic [SW-1:0]   STREAK_MAX = SW'(FAIR_LIMIT);

  typedef enum logic [1:0] {IDLE, HOST, SEQ, BLOCKED} state_e;
  typedef struct packed {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  state_e        state_q, state_d;
  wr_t           mem_q [FIFO_DEPTH];
  wr_t           head;
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [SW-1:0] streak_q, streak_d;
  logic          run_q, valid_q, ack_q, ovf_q;
  logic [4:0]    addr_q;
  logic [15:0]   data_q;
  logic          fifo_empty, fifo_full, in_window, seq_ok;
  logic          host_grant, seq_grant, push, drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  // Modular distance from the window start also covers a window ending at 1023.
  assign in_window  = (bus.master_count_in - BLOCK_START) <= SPAN;
  // While our ack is visible the sequencer still holds the old request; never regrant it.
  assign seq_ok     = run_q && !in_window && bus.seq_req_in && !ack_q;
  assign push       = bus.host_valid_in && (!fifo_full || host_grant);
  assign drop       = bus.host_valid_in && fifo_full && !host_grant;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values no matter in which order the simulator runs the processes.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // NOTE: each always_comb assigns a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    if (host_grant)                                       state_d = HOST;
    else if (seq_grant)                                   state_d = SEQ;
    else if (in_window && (!fifo_empty || bus.seq_req_in)) state_d = BLOCKED;
    else if (fifo_empty && !bus.seq_req_in)               state_d = IDLE;
  end

  always_comb begin
    host_grant = 1'b0;
    seq_grant  = 1'b0;
    if (run_q && !in_window && !fifo_empty && !(seq_ok && streak_q == STREAK_MAX))
      host_grant = 1'b1;
    else if (seq_ok)
      seq_grant = 1'b1;
  end

  always_comb begin
    streak_d = streak_q;
    if (seq_grant || !bus.seq_req_in)
      streak_d = '0;
    else if (host_grant && streak_q != STREAK_MAX)
      streak_d = streak_q + SW'(1);
  end

  // NOTE: the queue storage is not reset; the pointers alone say which entries are live.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= '{addr: bus.host_addr_in, data: bus.host_data_in};
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      streak_q <= '0;
      run_q    <= 1'b0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      run_q    <= 1'b1;
      streak_q <= streak_d;
      if (push)       wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (host_grant) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      valid_q  <= host_grant || seq_grant;
      ack_q    <= seq_grant;
      ovf_q    <= drop || (ovf_q && !bus.overflow_clr_in);
      if (host_grant) begin
        addr_q <= head.addr;
        data_q <= head.data;
      end else if (seq_grant) begin
        addr_q <= bus.seq_addr_in;
        data_q <= bus.seq_data_in;
      end
    end
  end

  assign bus.data_valid_out = valid_q;
  assign bus.seq_ack_out    = ack_q;
  assign bus.overflow_out   = ovf_q;
  assign bus.addr_out       = addr_q;
  assign bus.data_out       = data_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a queue-based model of the arbitration rules.
module tb_reg_write_arbiter;
  localparam int DEPTH  = 4;
  localparam int FAIR   = 4;
  localparam int WIN_LO = 1016;
  localparam int WIN_HI = 1023;

  typedef struct {
    logic [4:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk_in   = 1'b0;
  logic reset_in = 1'b0;
  reg_write_arbiter_if bus ();

  reg_write_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .FAIR_LIMIT (FAIR),
    .BLOCK_START(10'd1016),
    .BLOCK_END  (10'd1023)
  ) dut (
    .clk_in  (clk_in),
    .reset_in(reset_in),
    .bus     (bus.slave)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  wr_t         q[$];
  int          streak;
  bit          seq_last, run, ovf;
  bit          exp_valid, exp_ack;
  logic [4:0]  exp_addr;
  logic [15:0] exp_data;
  int          mc;
  int          eval_mc;
  bit          seq_drop_pending;

  // Observed writes, for the hand-computed scenario checks
  wr_t   log_w[$];
  int    log_mc[$];
  string kinds;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    check("data_valid_out", 32'(bus.data_valid_out), 32'(exp_valid));
    check("seq_ack_out",    32'(bus.seq_ack_out),    32'(exp_ack));
    check("overflow_out",   32'(bus.overflow_out),   32'(ovf));
    check("addr_out",       32'(bus.addr_out),       32'(exp_addr));
    check("data_out",       32'(bus.data_out),       32'(exp_data));
  endtask

  // One evaluation cycle of the arbitration rules, using this cycle's inputs.
  task automatic model_eval();
    bit  win, can, seq_ok, hg, sg, drop;
    wr_t w;
    win    = (mc >= WIN_LO) && (mc <= WIN_HI);
    can    = run && !win;
    seq_ok = can && bus.seq_req_in && !seq_last;
    hg     = can && (q.size() > 0) && !(seq_ok && streak == FAIR);
    sg     = !hg && seq_ok;
    exp_valid = hg || sg;
    exp_ack   = sg;
    if (hg) begin
      w = q.pop_front();
      exp_addr = w.addr;
      exp_data = w.data;
    end else if (sg) begin
      exp_addr = bus.seq_addr_in;
      exp_data = bus.seq_data_in;
    end
    if (sg || !bus.seq_req_in) streak = 0;
    else if (hg && streak < FAIR) streak++;
    drop = 1'b0;
    if (bus.host_valid_in) begin
      if (q.size() < DEPTH) begin
        w.addr = bus.host_addr_in;
        w.data = bus.host_data_in;
        q.push_back(w);
      end else drop = 1'b1;
    end
    ovf      = drop ? 1'b1 : (bus.overflow_clr_in ? 1'b0 : ovf);
    seq_last = sg;
    run      = 1'b1;
  endtask

  task automatic set_mc(input int v);
    mc = v;
    bus.master_count_in = 10'(v);
  endtask

  task automatic tick();
    wr_t w;
    model_eval();
    eval_mc = mc;
    @(posedge clk_in);
    #1;
    compare();
    if (bus.data_valid_out) begin
      w.addr = bus.addr_out;
      w.data = bus.data_out;
      log_w.push_back(w);
      log_mc.push_back(eval_mc);
      kinds = {kinds, bus.seq_ack_out ? "S" : "H"};
    end
    bus.host_valid_in   = 1'b0;
    bus.overflow_clr_in = 1'b0;
    set_mc((mc + 1) % 1024);
    // Sequencer agent: keep the stale request during the ack cycle, drop it after.
    if (seq_drop_pending) begin
      bus.seq_req_in   = 1'b0;
      seq_drop_pending = 1'b0;
    end else if (exp_ack) seq_drop_pending = 1'b1;
  endtask

  task automatic clear_log();
    log_w.delete();
    log_mc.delete();
    kinds = "";
  endtask

  task automatic host(input logic [4:0] a, input logic [15:0] d);
    bus.host_addr_in  = a;
    bus.host_data_in  = d;
    bus.host_valid_in = 1'b1;
  endtask

  task automatic seq(input logic [4:0] a, input logic [15:0] d);
    bus.seq_addr_in = a;
    bus.seq_data_in = d;
    bus.seq_req_in  = 1'b1;
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    #1;
    q.delete();
    streak = 0; seq_last = 0; run = 0; ovf = 0;
    exp_valid = 0; exp_ack = 0; exp_addr = '0; exp_data = '0;
    seq_drop_pending    = 1'b0;
    bus.host_valid_in   = 1'b0;
    bus.seq_req_in      = 1'b0;
    bus.overflow_clr_in = 1'b0;
    compare();
    repeat (2) @(posedge clk_in);
    #1;
    compare();
    reset_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    string exp_k;
    int    n_s;
    int    rate;
    bus.host_addr_in = '0; bus.host_data_in = '0; bus.host_valid_in = 1'b0;
    bus.seq_addr_in  = '0; bus.seq_data_in  = '0; bus.seq_req_in    = 1'b0;
    bus.overflow_clr_in = 1'b0;
    set_mc(0);

    // Single host write: visible exactly two cycles after the valid pulse.
    do_reset();
    set_mc(100);
    tick();
    host(5'h03, 16'h1234);
    tick();
    check("t1_n1_valid", 32'(bus.data_valid_out), 32'd0);
    tick();
    check("t1_n2_valid", 32'(bus.data_valid_out), 32'd1);
    check("t1_n2_addr",  32'(bus.addr_out),       32'h03);
    check("t1_n2_data",  32'(bus.data_out),       32'h1234);
    check("t1_n2_ack",   32'(bus.seq_ack_out),    32'd0);

    // Five writes inside the window: fifth dropped, four drained in order after the wrap.
    do_reset();
    set_mc(1015);
    tick();
    clear_log();
    for (int i = 0; i < 5; i++) begin
      host(5'(i + 1), 16'hA000 + 16'(i));
      tick();
    end
    check("t2_overflow", 32'(bus.overflow_out), 32'd1);
    repeat (8) tick();
    check("t2_count", 32'(log_w.size()), 32'd4);
    if (log_w.size() == 4) begin
      check("t2_first_eval_mc", 32'(log_mc[0]), 32'd0);
      for (int i = 0; i < 4; i++) begin
        check("t2_addr", 32'(log_w[i].addr), 32'(i + 1));
        check("t2_data", 32'(log_w[i].data), 32'hA000 + 32'(i));
      end
    end

    // Fairness: four host grants, one sequencer grant, then host again.
    do_reset();
    set_mc(200);
    tick();
    clear_log();
    host(5'd1, 16'hB000);
    tick();
    for (int i = 1; i < 10; i++) begin
      host(5'(i + 1), 16'hB000 + 16'(i));
      if (i == 1) seq(5'h1F, 16'hCAFE);
      tick();
    end
    repeat (6) tick();
    exp_k = "HHHHSH";
    check("t3_len_ok", 32'(kinds.len() >= 6), 32'd1);
    for (int i = 0; i < 6 && i < kinds.len(); i++)
      check("t3_kind", 32'(kinds[i]), 32'(exp_k[i]));
    n_s = 0;
    for (int i = 0; i < kinds.len(); i++) if (kinds[i] == "S") n_s++;
    check("t3_ack_count", 32'(n_s), 32'd1);
    if (log_w.size() > 4) check("t3_seq_data", 32'(log_w[4].data), 32'hCAFE);

    // Sequencer request raised at window start waits until count 0 is evaluated.
    do_reset();
    set_mc(1014);
    tick();
    tick();
    clear_log();
    seq(5'h07, 16'h5EED);
    repeat (12) tick();
    check("t4_count", 32'(log_w.size()), 32'd1);
    if (log_w.size() == 1) begin
      check("t4_eval_mc", 32'(log_mc[0]), 32'd0);
      check("t4_kind",    32'(kinds[0]),  32'("S"));
      check("t4_data",    32'(log_w[0].data), 32'h5EED);
    end

    // Full queue: drop sets overflow, clear+drop keeps it, push+pop on full is accepted.
    do_reset();
    set_mc(1015);
    tick();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      host(5'(10 + i), 16'hC000 + 16'(i));
      tick();
    end
    host(5'd20, 16'hDEAD);
    tick();
    check("t5_ovf_set", 32'(bus.overflow_out), 32'd1);
    host(5'd21, 16'hBEEF);
    bus.overflow_clr_in = 1'b1;
    tick();
    check("t5_ovf_clr_and_set", 32'(bus.overflow_out), 32'd1);
    bus.overflow_clr_in = 1'b1;
    tick();
    check("t5_ovf_cleared", 32'(bus.overflow_out), 32'd0);
    tick();
    host(5'd22, 16'hF00D);
    tick();
    check("t5_ovf_pushpop", 32'(bus.overflow_out), 32'd0);
    repeat (8) tick();
    check("t5_count", 32'(log_w.size()), 32'd5);
    if (log_w.size() == 5) begin
      for (int i = 0; i < 4; i++) check("t5_data", 32'(log_w[i].data), 32'hC000 + 32'(i));
      check("t5_last_data", 32'(log_w[4].data), 32'hF00D);
    end

    // Reset with queued entries: nothing stale comes out afterwards.
    do_reset();
    set_mc(1015);
    tick();
    for (int i = 0; i < 3; i++) begin
      host(5'(i), 16'hE000 + 16'(i));
      tick();
    end
    do_reset();
    set_mc(300);
    clear_log();
    repeat (10) tick();
    check("t6_no_stale", 32'(log_w.size()), 32'd0);

    // Randomized traffic with varying host load, sequencer requests and window hits.
    do_reset();
    set_mc(0);
    rate = 30;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) rate = $urandom_range(10, 100);
      if (cyc == 1500) do_reset();
      if ($urandom_range(0, 299) == 0) set_mc(1005);
      if ($urandom_range(0, 99) < rate) host(5'($urandom), 16'($urandom));
      if (!bus.seq_req_in && $urandom_range(0, 9) == 0) seq(5'($urandom), 16'($urandom));
      if ($urandom_range(0, 49) == 0) bus.overflow_clr_in = 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
